accum_unit_p: RTL and testbench

//  Parametrised, pipelined signed/unsigned accumulator; successor to the fixed 8-bit board accumulator.

---
 rtl/accum_pkg.sv | 21 ++
 rtl/accum_unit_p_addsub.sv | 29 ++
 rtl/accum_unit_p.sv | 117 +++++++++++
 tb/tb_accum_unit_p.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the pipelined accumulator: operation encoding and
// saturation limit helpers.
package accum_pkg;

  // Operation encoding for the Sub input / registered Sub_r.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest signed value representable in w bits (w <= 64), zero-extended.
  function automatic logic [63:0] sat_max(input int w);
    logic [63:0] m;
    m = 64'd1 << (w - 1);
    return m - 64'd1;
  endfunction

  // Most negative signed value in w bits (w <= 64), as a w-bit pattern.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/accum_unit_p_addsub.sv
// Combinational add/subtract core. Subtraction is done as S + ~A + 1 so the
// carry-out reads as "no borrow" for subtracts.
module addsub_core
  import accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_r,
  output logic             o_c,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;

  // Effective addend, full-width sum, and signed overflow detection.
  always_comb begin
    w_b   = (i_sub == OP_SUB) ? ~i_a : i_a;
    w_sum = {1'b0, i_s} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
    o_r   = w_sum[WIDTH-1:0];
    o_c   = w_sum[WIDTH];
    // Overflow: operands share a sign and the result sign differs from it.
    o_ovf = (i_s[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_s[WIDTH-1]);
  end

endmodule

// File: rtl/accum_unit_p.sv
// Two-stage accumulator. Stage 1 registers the operand and operation; stage 2
// folds it into the running sum S. Back-to-back ops chain through S directly,
// so there is no hazard and no stall.
module accum_unit_p
  import accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 4
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_ovf_sticky,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_a;
  logic             r_sub;
  logic             r_v1;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_ovf;
  logic             r_sticky;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_r;
  logic             w_c;
  logic             w_ovf;
  logic [WIDTH-1:0] w_s_next;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_min;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .i_s   (r_s),
    .i_a   (r_a),
    .i_sub (r_sub),
    .o_r   (w_r),
    .o_c   (w_c),
    .o_ovf (w_ovf)
  );

  // Saturation mux: clamp toward the sign of the old sum when overflow fires.
  always_comb begin
    w_max    = WIDTH'(sat_max(WIDTH));
    w_min    = WIDTH'(sat_min(WIDTH));
    w_s_next = w_r;
    if ((SATURATE != 0) && w_ovf) begin
      w_s_next = r_s[WIDTH-1] ? w_min : w_max;
    end
  end

  // Stage 1: capture operand and operation when a new op is started.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_a   <= '0;
      r_sub <= OP_ADD;
      r_v1  <= 1'b0;
    end else if (i_clear) begin
      r_a   <= '0;
      r_sub <= OP_ADD;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= i_en;
      if (i_en) begin
        r_a   <= i_a;
        r_sub <= i_sub;
      end
    end
  end

  // Stage 2: update sum, flags and op counter; Valid mirrors stage-1 occupancy.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_s      <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_s      <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_valid <= r_v1;
      if (r_v1) begin
        r_s      <= w_s_next;
        r_carry  <= w_c;
        r_ovf    <= w_ovf;
        r_sticky <= r_sticky | w_ovf;
        if (!(&r_count)) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign o_s          = r_s;
  assign o_carry      = r_carry;
  assign o_overflow   = r_ovf;
  assign o_ovf_sticky = r_sticky;
  assign o_valid      = r_valid;
  assign o_count      = r_count;

endmodule

// File: tb/tb_accum_unit_p.sv
// Bench for accum_unit_p: a wrapping and a saturating instance share stimulus
// and are compared every cycle against an integer-arithmetic reference model.
module tb_accum_unit_p;

  localparam int W  = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          en = 1'b0;
  logic          sub = 1'b0;
  logic [W-1:0]  a = '0;

  logic [W-1:0]  s0, s1;
  logic          c0, c1, o0, o1, st0, st1, v0, v1;
  logic [CW-1:0] n0, n1;

  accum_unit_p #(.WIDTH(W), .SATURATE(0), .CNT_W(CW)) u_wrap (
    .i_clock(clk), .i_resetn(rst_n), .i_clear(clear), .i_en(en), .i_sub(sub),
    .i_a(a), .o_s(s0), .o_carry(c0), .o_overflow(o0), .o_ovf_sticky(st0),
    .o_valid(v0), .o_count(n0)
  );

  accum_unit_p #(.WIDTH(W), .SATURATE(1), .CNT_W(CW)) u_sat (
    .i_clock(clk), .i_resetn(rst_n), .i_clear(clear), .i_en(en), .i_sub(sub),
    .i_a(a), .o_s(s1), .o_carry(c1), .o_overflow(o1), .o_ovf_sticky(st1),
    .o_valid(v1), .o_count(n1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 = wrapping accumulator, index 1 = saturating accumulator.
  int m_s[2];
  int m_c[2];
  int m_o[2];
  int m_st[2];
  int m_cnt[2];
  int m_v;
  // One accepted-but-not-yet-applied operation (sampled last edge).
  int p_v, p_sub, p_a;
  // Operands that were accepted and await their result (expected queue).
  logic [W-1:0] exp_q[$];

  function automatic int to_signed(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s[i] = 0; m_c[i] = 0; m_o[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
    end
    m_v = 0; p_v = 0; p_sub = 0; p_a = 0;
    exp_q.delete();
  endtask

  task automatic model_apply(input int sb, input int av);
    for (int i = 0; i < 2; i++) begin
      int us, rs, ures, cy, ov;
      us = m_s[i];
      if (sb != 0) begin
        rs   = to_signed(us) - to_signed(av);
        cy   = (us >= av) ? 1 : 0;
        ures = (us - av + 256) % 256;
      end else begin
        rs   = to_signed(us) + to_signed(av);
        cy   = (us + av > 255) ? 1 : 0;
        ures = (us + av) % 256;
      end
      ov = (rs > 127 || rs < -128) ? 1 : 0;
      if (i == 1 && ov == 1) m_s[i] = (rs > 127) ? 127 : 128;
      else                   m_s[i] = ures;
      m_c[i] = cy;
      m_o[i] = ov;
      if (ov == 1) m_st[i] = 1;
      if (m_cnt[i] < 15) m_cnt[i]++;
    end
  endtask

  task automatic compare_all();
    check("wrap_s",      32'(s0),  32'(m_s[0]));
    check("wrap_carry",  32'(c0),  32'(m_c[0]));
    check("wrap_ovf",    32'(o0),  32'(m_o[0]));
    check("wrap_sticky", 32'(st0), 32'(m_st[0]));
    check("wrap_valid",  32'(v0),  32'(m_v));
    check("wrap_count",  32'(n0),  32'(m_cnt[0]));
    check("sat_s",       32'(s1),  32'(m_s[1]));
    check("sat_carry",   32'(c1),  32'(m_c[1]));
    check("sat_ovf",     32'(o1),  32'(m_o[1]));
    check("sat_sticky",  32'(st1), 32'(m_st[1]));
    check("sat_valid",   32'(v1),  32'(m_v));
    check("sat_count",   32'(n1),  32'(m_cnt[1]));
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one cycle, advance one edge, update model, compare.
  task automatic do_cycle(input bit i_clr, input bit i_en, input bit i_sb, input int i_a);
    logic [W-1:0] av;
    av    = W'(i_a);
    clear = i_clr; en = i_en; sub = i_sb; a = av;
    @(posedge clk);
    #1;
    if (i_clr) begin
      for (int i = 0; i < 2; i++) begin
        m_s[i] = 0; m_c[i] = 0; m_o[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      end
      m_v = 0; p_v = 0;
      exp_q.delete();
    end else begin
      m_v = p_v;
      if (p_v != 0) begin
        void'(exp_q.pop_front());
        model_apply(p_sub, p_a);
      end
      p_v = i_en ? 1 : 0; p_sub = i_sb ? 1 : 0; p_a = int'(av);
      if (i_en) exp_q.push_back(av);
    end
    clear = 1'b0; en = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 1'b0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();                      // reset state
    rst_n = 1'b1;

    // Reset asserted while an op is pending: outputs clear at once, no Valid later.
    do_cycle(1'b0, 1'b1, 1'b0, 8'h05);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h11);  // first op lands, second pending
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst_n = 1'b1;
    idle(2);

    // Back-to-back adds.
    do_cycle(1'b0, 1'b1, 1'b0, 8'h05);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h03);
    check("b2b_first_s", 32'(s0), 32'h05);
    do_cycle(1'b0, 1'b0, 1'b0, 0);
    check("b2b_second_s", 32'(s0), 32'h08);
    check("b2b_count", 32'(n0), 32'd2);

    // Positive signed overflow: 0x20 + 0x70.
    do_cycle(1'b1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h20);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h70);
    idle(1);
    check("ovf_wrap_s", 32'(s0), 32'h90);
    check("ovf_sat_s",  32'(s1), 32'h7F);

    // Borrow without overflow, then negative overflow in saturate mode.
    do_cycle(1'b1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h08);
    do_cycle(1'b0, 1'b1, 1'b1, 8'h09);
    idle(1);
    check("borrow_s", 32'(s0), 32'hFF);
    do_cycle(1'b1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h80);
    do_cycle(1'b0, 1'b1, 1'b1, 8'h01);
    idle(1);
    check("neg_sat_s", 32'(s1), 32'h80);

    // Unsigned wrap with carry, then counter saturation.
    do_cycle(1'b1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h01);
    do_cycle(1'b0, 1'b1, 1'b0, 8'hFF);
    idle(1);
    check("wrap_zero_s", 32'(s0), 32'h00);
    check("wrap_zero_c", 32'(c0), 32'd1);
    for (int k = 0; k < 20; k++) do_cycle(1'b0, 1'b1, k[0], $urandom_range(0, 255));
    idle(1);
    check("count_sat", 32'(n0), 32'hF);

    // Clear coinciding with En while S is nonzero.
    do_cycle(1'b1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h42);
    idle(1);
    do_cycle(1'b1, 1'b1, 1'b0, 8'h13);
    do_cycle(1'b0, 1'b0, 1'b0, 0);
    check("clear_no_valid", 32'(v0), 32'd0);
    check("clear_s", 32'(s0), 32'h00);

    // Randomised traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      do_cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 255));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
